// File: rtl/scene_loader_pkg.sv
// scene_loader shared types
// instance record layout, host opcodes and loader states
package scene_loader_pkg;

  typedef struct packed {
    logic [5:0]  model_id;
    logic [15:0] pos_x;
    logic [15:0] pos_y;
    logic [15:0] pos_z;
    logic [8:0]  yaw;
  } modelinstance_t;

  localparam int INST_BITS  = $bits(modelinstance_t);
  localparam int INST_BYTES = (INST_BITS + 7) / 8;

  typedef enum logic [7:0] {
    OP_ADD = 8'hA0,
    OP_END = 8'hA1
  } cmd_opcode_e;

  typedef enum logic [2:0] {
    IDLE,
    PAYLOAD,
    SKIP,
    WRITE,
    WAIT_END
  } loader_state_e;

endpackage

// File: rtl/scene_loader.sv
// scene_loader: host byte stream -> scene buffer writer
// assembles ADD_INSTANCE records and commits scenes on END_SCENE
module scene_loader
  import scene_loader_pkg::*;
#(
  parameter int MAX_TRANSFORMS = 50,
  localparam int CW = $clog2(MAX_TRANSFORMS + 1)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           in_valid,
  input  logic [7:0]     in_data,
  output logic           in_ready,
  output logic           write_en,
  output modelinstance_t write_transform,
  output logic           write_ready,
  input  logic           write_full,
  output logic           err_opcode,
  output logic           err_overflow,
  output logic [CW-1:0]  inst_count
);

  localparam int BW = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(INST_BYTES - 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_TRANSFORMS);

  loader_state_e state;
  loader_state_e state_nx;

  // Only the bytes before the last one need storing; the
  // final byte is taken straight from in_data.
  logic [INST_BITS-9:0] shreg;
  logic [INST_BITS-1:0] shreg_nx;
  logic [BW-1:0]        cnt;

  logic take;
  logic last_byte;
  logic at_cap;
  logic is_add;
  logic is_end;
  logic wr_done;
  logic end_done;

  assign in_ready = (state == IDLE)
                 || (state == PAYLOAD)
                 || (state == SKIP);
  assign write_en = (state == WRITE);

  assign take      = in_valid && in_ready;
  assign last_byte = (cnt == LAST_BYTE);
  assign at_cap    = (inst_count == MAX_CNT);
  assign is_add    = (in_data == OP_ADD);
  assign is_end    = (in_data == OP_END);
  assign shreg_nx  = {shreg, in_data};

  // At capacity write_full means "scene full", not "slot busy",
  // so END may proceed.
  assign wr_done  = (state == WRITE) && !write_full;
  assign end_done = (state == WAIT_END)
                 && !(write_full && !at_cap);

  // state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (take) begin
          unique case (1'b1)
            is_add && !at_cap: state_nx = PAYLOAD;
            is_add && at_cap:  state_nx = SKIP;
            is_end:            state_nx = WAIT_END;
            default:           state_nx = IDLE;
          endcase
        end
      end
      PAYLOAD: begin
        if (take && last_byte) begin
          state_nx = WRITE;
        end
      end
      SKIP: begin
        if (take && last_byte) begin
          state_nx = IDLE;
        end
      end
      WRITE: begin
        if (wr_done) begin
          state_nx = IDLE;
        end
      end
      WAIT_END: begin
        if (end_done) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // payload assembly and instance counting
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt             <= '0;
      shreg           <= '0;
      write_transform <= '0;
      inst_count      <= '0;
    end else begin
      if (take) begin
        if (state == IDLE) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + BW'(1);
        end
      end
      if (take && state == PAYLOAD) begin
        shreg <= shreg_nx[INST_BITS-9:0];
        if (last_byte) begin
          write_transform <= modelinstance_t'(shreg_nx);
        end
      end
      if (wr_done) begin
        inst_count <= inst_count + CW'(1);
      end else if (end_done) begin
        inst_count <= '0;
      end
    end
  end

  // single-cycle status pulses
  always_ff @(posedge clk) begin
    if (!rstn) begin
      write_ready  <= 1'b0;
      err_opcode   <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      write_ready  <= end_done;
      err_opcode   <= take && (state == IDLE)
                   && !is_add && !is_end;
      err_overflow <= take && (state == IDLE)
                   && is_add && at_cap;
    end
  end

endmodule

// File: tb/tb_scene_loader.sv
// tb_scene_loader: random byte streams vs a command-level model
// includes a two-slot scene buffer model driving write_full
module tb_scene_loader;
  import scene_loader_pkg::*;

  localparam int MAX = 4;
  localparam int CW  = $clog2(MAX + 1);
  localparam int TMO = 400;

  typedef logic [7:0] bq_t[$];
  typedef logic [INST_BITS-1:0] rec_t;

  logic           clk = 1'b0;
  logic           rstn;
  logic           in_valid;
  logic [7:0]     in_data;
  logic           in_ready;
  logic           write_en;
  modelinstance_t write_transform;
  logic           write_ready;
  logic           write_full;
  logic           err_opcode;
  logic           err_overflow;
  logic [CW-1:0]  inst_count;

  int n_checks = 0;
  int n_fail   = 0;

  // scene buffer model (SCENE_COUNT = 2)
  int   committed = 0;
  int   cur_cnt   = 0;
  logic reader_en = 1'b1;
  rec_t buf_recs[$];
  int   buf_sizes[$];
  rec_t rd_recs[$];
  int   rd_sizes[$];

  // observations
  rec_t obs_w[$];
  int   obs_rdy, obs_eop, obs_eov;
  logic prev_stall = 1'b0;
  rec_t prev_wt;

  // expectations
  rec_t exp_w[$];
  int   exp_sizes[$];
  int   exp_rdy, exp_eop, exp_eov;
  int   model_cnt = 0;

  scene_loader #(.MAX_TRANSFORMS(MAX)) dut (
    .clk(clk),
    .rstn(rstn),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .write_en(write_en),
    .write_transform(write_transform),
    .write_ready(write_ready),
    .write_full(write_full),
    .err_opcode(err_opcode),
    .err_overflow(err_overflow),
    .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  assign write_full = (committed >= 2) || (cur_cnt >= MAX);

  initial forever begin
    @(posedge clk);
    if (!rstn) begin
      committed <= 0;
      cur_cnt   <= 0;
      buf_recs.delete();
      buf_sizes.delete();
    end else begin
      if (write_en && !write_full) begin
        buf_recs.push_back(rec_t'(write_transform));
        cur_cnt <= cur_cnt + 1;
      end
      if (write_ready) begin
        buf_sizes.push_back(cur_cnt);
        cur_cnt <= 0;
      end
      if (reader_en && committed > 0) begin
        repeat (buf_sizes[0]) rd_recs.push_back(buf_recs.pop_front());
        rd_sizes.push_back(buf_sizes.pop_front());
      end
      committed <= committed + (write_ready ? 1 : 0)
                 - ((reader_en && committed > 0) ? 1 : 0);
    end
  end

  initial forever begin
    @(negedge clk);
    if (rstn) begin
      if (write_en && !write_full) obs_w.push_back(rec_t'(write_transform));
      if (write_ready)  obs_rdy++;
      if (err_opcode)   obs_eop++;
      if (err_overflow) obs_eov++;
      if (prev_stall && write_en) begin
        n_checks++;
        if (rec_t'(write_transform) !== prev_wt) begin
          n_fail++;
          $display("FAIL hold: write_transform %h during stall, required %h",
                   rec_t'(write_transform), prev_wt);
        end
      end
      if (write_ready) begin
        n_checks++;
        if (write_en !== 1'b0) begin
          n_fail++;
          $display("FAIL exclusive: write_en %b with write_ready, required 0", write_en);
        end
      end
      prev_stall = write_en && write_full;
      prev_wt    = rec_t'(write_transform);
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clear_obs();
    obs_w.delete(); exp_w.delete(); exp_sizes.delete();
    rd_recs.delete(); rd_sizes.delete();
    obs_rdy = 0; obs_eop = 0; obs_eov = 0;
    exp_rdy = 0; exp_eop = 0; exp_eov = 0;
  endtask

  // command-level model of the host protocol
  task automatic model_cmds(input bq_t q);
    int i = 0;
    logic [INST_BYTES*8-1:0] v;
    while (i < q.size()) begin
      if (q[i] == 8'hA0) begin
        if (model_cnt < MAX) begin
          v = '0;
          for (int k = 1; k <= INST_BYTES; k++) v = {v[INST_BYTES*8-9:0], q[i+k]};
          exp_w.push_back(v[INST_BITS-1:0]);
          model_cnt++;
        end else begin
          exp_eov++;
        end
        i += 1 + INST_BYTES;
      end else if (q[i] == 8'hA1) begin
        exp_rdy++;
        exp_sizes.push_back(model_cnt);
        model_cnt = 0;
        i++;
      end else begin
        exp_eop++;
        i++;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_byte: in_ready low for %0d cycles, byte %02h required accept", n, b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_seq(input bq_t q);
    model_cmds(q);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic push_add(inout bq_t q);
    q.push_back(8'hA0);
    repeat (INST_BYTES) q.push_back(8'($urandom));
  endtask

  task automatic settle();
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < TMO) begin
      @(negedge clk);
      n++;
      if (in_ready && !write_ready) quiet++;
      else quiet = 0;
    end
    while (reader_en && committed != 0 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= TMO) begin
      n_fail++;
      $display("FAIL settle: busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({in_ready, write_en, write_ready, err_opcode, err_overflow} !== 5'b10000
        || inst_count !== '0 || rec_t'(write_transform) !== '0) begin
      n_fail++;
      $display("FAIL reset: rdy/wen/wrdy/eop/eov=%b%b%b%b%b cnt=%0d wt=%h, required 10000 0 0",
               in_ready, write_en, write_ready, err_opcode, err_overflow,
               inst_count, rec_t'(write_transform));
    end
  endtask

  task automatic test_single();
    bq_t q;
    clear_obs();
    reader_en = 1'b1;
    push_add(q);
    send_seq(q);
    @(negedge clk);
    n_checks++;
    if (write_en !== 1'b1) begin
      n_fail++;
      $display("FAIL single_latency: write_en %b, required 1", write_en);
    end
    q.delete();
    q.push_back(8'hA1);
    send_seq(q);
    settle();
    n_checks++;
    if (obs_w.size() != 1 || obs_w[0] !== exp_w[0]) begin
      n_fail++;
      $display("FAIL single_rec: %0d writes first %h, required 1 of %h",
               obs_w.size(), obs_w.size() ? obs_w[0] : '0, exp_w[0]);
    end
    n_checks++;
    if (obs_rdy != exp_rdy) begin
      n_fail++;
      $display("FAIL single_ready: %0d pulses, required %0d", obs_rdy, exp_rdy);
    end
    n_checks++;
    if (rd_sizes.size() != 1 || rd_recs.size() != 1 || rd_recs[0] !== exp_w[0]) begin
      n_fail++;
      $display("FAIL single_reader: %0d scenes %0d recs, required 1 scene holding %h",
               rd_sizes.size(), rd_recs.size(), exp_w[0]);
    end
  endtask

  task automatic test_full_stall();
    bq_t q;
    clear_obs();
    reader_en = 1'b0;
    repeat (2) begin
      push_add(q); push_add(q); q.push_back(8'hA1);
    end
    push_add(q);
    send_seq(q);
    repeat (4) @(negedge clk);
    n_checks++;
    if (write_en !== 1'b1 || in_ready !== 1'b0 || obs_rdy != 2 || obs_w.size() != 4) begin
      n_fail++;
      $display("FAIL stall: wen=%b rdy=%b pulses=%0d writes=%0d, required 1 0 2 4",
               write_en, in_ready, obs_rdy, obs_w.size());
    end
    reader_en = 1'b1;
    q.delete();
    push_add(q); q.push_back(8'hA1);
    send_seq(q);
    settle();
    n_checks++;
    if (obs_w.size() != exp_w.size()) begin
      n_fail++;
      $display("FAIL stall_count: %0d writes, required %0d", obs_w.size(), exp_w.size());
    end else begin
      foreach (exp_w[i]) begin
        n_checks++;
        if (obs_w[i] !== exp_w[i]) begin
          n_fail++;
          $display("FAIL stall_rec%0d: %h, required %h", i, obs_w[i], exp_w[i]);
        end
      end
    end
    n_checks++;
    if (obs_rdy != 3 || rd_sizes.size() != 3 || rd_sizes[0] != 2 || rd_sizes[2] != 2) begin
      n_fail++;
      $display("FAIL stall_scenes: pulses=%0d scenes=%0d, required 3 scenes of 2",
               obs_rdy, rd_sizes.size());
    end
  endtask

  task automatic test_overflow();
    bq_t q;
    clear_obs();
    reader_en = 1'b1;
    repeat (5) push_add(q);
    send_seq(q);
    settle();
    n_checks++;
    if (inst_count !== CW'(model_cnt) || obs_eov != exp_eov || obs_w.size() != exp_w.size()) begin
      n_fail++;
      $display("FAIL overflow: cnt=%0d eov=%0d writes=%0d, required %0d %0d %0d",
               inst_count, obs_eov, obs_w.size(), model_cnt, exp_eov, exp_w.size());
    end
    foreach (exp_w[i]) begin
      n_checks++;
      if (i >= obs_w.size() || obs_w[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL overflow_rec%0d: wrong or missing, required %h", i, exp_w[i]);
      end
    end
    q.delete();
    q.push_back(8'hA1);
    send_seq(q);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (write_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_end: write_ready %b one cycle after END, required 1", write_ready);
    end
    settle();
    n_checks++;
    if (inst_count !== '0 || obs_rdy != 1) begin
      n_fail++;
      $display("FAIL overflow_clear: cnt=%0d pulses=%0d, required 0 1", inst_count, obs_rdy);
    end
  endtask

  task automatic test_bad_opcode();
    bq_t q;
    clear_obs();
    q.push_back(8'h55);
    send_seq(q);
    @(negedge clk);
    n_checks++;
    if (err_opcode !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_op: err_opcode=%b in_ready=%b, required 1 1", err_opcode, in_ready);
    end
    q.delete();
    push_add(q);
    q.push_back(8'($urandom_range(0, 8'h9F)));
    q.push_back(8'hA1);
    send_seq(q);
    settle();
    n_checks++;
    if (obs_eop != exp_eop || obs_w.size() != 1 || obs_w[0] !== exp_w[0] || obs_rdy != 1) begin
      n_fail++;
      $display("FAIL bad_op_follow: eop=%0d writes=%0d pulses=%0d, required %0d 1 1 rec %h",
               obs_eop, obs_w.size(), obs_rdy, exp_eop, exp_w[0]);
    end
  endtask

  task automatic test_empty_scene();
    bq_t q;
    clear_obs();
    q.push_back(8'hA1);
    send_seq(q);
    @(negedge clk);
    n_checks++;
    if (write_ready !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_wait: write_ready=%b in_ready=%b, required 0 0", write_ready, in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (write_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_pulse: write_ready %b, required 1", write_ready);
    end
    settle();
    n_checks++;
    if (rd_sizes.size() != 1 || rd_sizes[0] != 0 || obs_w.size() != 0) begin
      n_fail++;
      $display("FAIL empty_scene: %0d scenes %0d writes, required one size-0 scene",
               rd_sizes.size(), obs_w.size());
    end
  endtask

  task automatic test_mid_reset();
    bq_t q;
    send_byte(8'hA0);
    repeat (INST_BYTES / 2) send_byte(8'($urandom));
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    test_reset();
    rstn = 1'b1;
    model_cnt = 0;
    clear_obs();
    push_add(q);
    q.push_back(8'hA1);
    send_seq(q);
    settle();
    n_checks++;
    if (obs_w.size() != 1 || obs_w[0] !== exp_w[0] || obs_rdy != 1) begin
      n_fail++;
      $display("FAIL mid_reset: writes=%0d first=%h pulses=%0d, required 1 %h 1",
               obs_w.size(), obs_w.size() ? obs_w[0] : '0, obs_rdy, exp_w[0]);
    end
  endtask

  task automatic test_back_to_back();
    bq_t q;
    int k;
    clear_obs();
    for (int c = 0; c < 30; c++) begin
      k = $urandom_range(0, 19);
      if (k < 14) push_add(q);
      else if (k < 18) q.push_back(8'hA1);
      else q.push_back(8'($urandom_range(0, 8'h9F)));
    end
    q.push_back(8'hA1);
    send_seq(q);
    settle();
    n_checks++;
    if (obs_w.size() != exp_w.size()) begin
      n_fail++;
      $display("FAIL b2b_count: %0d writes, required %0d", obs_w.size(), exp_w.size());
    end else begin
      foreach (exp_w[i]) begin
        n_checks++;
        if (obs_w[i] !== exp_w[i]) begin
          n_fail++;
          $display("FAIL b2b_rec%0d: %h, required %h", i, obs_w[i], exp_w[i]);
        end
      end
    end
    n_checks++;
    if (obs_rdy != exp_rdy || obs_eop != exp_eop || obs_eov != exp_eov) begin
      n_fail++;
      $display("FAIL b2b_pulses: rdy=%0d eop=%0d eov=%0d, required %0d %0d %0d",
               obs_rdy, obs_eop, obs_eov, exp_rdy, exp_eop, exp_eov);
    end
    n_checks++;
    if (rd_sizes.size() != exp_sizes.size()) begin
      n_fail++;
      $display("FAIL b2b_scenes: %0d scenes, required %0d", rd_sizes.size(), exp_sizes.size());
    end else begin
      foreach (exp_sizes[i]) begin
        n_checks++;
        if (rd_sizes[i] != exp_sizes[i]) begin
          n_fail++;
          $display("FAIL b2b_size%0d: %0d, required %0d", i, rd_sizes[i], exp_sizes[i]);
        end
      end
    end
  endtask

  initial begin
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rstn = 1'b1;
    test_single();
    test_full_stall();
    test_overflow();
    test_bad_opcode();
    test_empty_scene();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
